putc_uart_tx: RTL and testbench

//  Device end of the CU putc interface: accepts single-cycle putc/putc_char strobes,

---
 rtl/putc_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_putc_uart_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/putc_uart_tx.sv
// CU putc sink: byte FIFO feeding an 8N1 LSB-first UART transmitter.
// Optional build macro PUTC_CRLF_EN expands each 0x0A into the pair 0x0D,0x0A on the line.
module putc_uart_tx #(
  parameter int CLK_DIV   = 104,
  parameter int FIFO_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       putc,
  input  logic [7:0] putc_char,
  output logic       putc_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] dbg_state
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_LOG2:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]         mem_q [DEPTH];
`ifdef PUTC_CRLF_EN
  logic               cr_q, cr_d;
`endif

  logic       empty, full, push, pop, baud_end;
  logic [7:0] head;

  // Handshake: a byte is taken on any posedge where putc && putc_ready; putc while
  // !putc_ready loses the byte and latches overflow. There is no back-pressure beyond that.
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[FIFO_LOG2-1:0] == rd_q[FIFO_LOG2-1:0]) &&
                    (wr_q[FIFO_LOG2] != rd_q[FIFO_LOG2]);
  assign head     = mem_q[rd_q[FIFO_LOG2-1:0]];
  assign push     = putc && !full;
  assign baud_end = (baud_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef PUTC_CRLF_EN
    cr_d    = cr_q;
`endif
    ovf_d   = ovf_q | (putc & full);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          state_d = START;
          tx_d    = 1'b0;
`ifdef PUTC_CRLF_EN
          // LF stays at the head until its CR has gone out.
          if (head == 8'h0A && !cr_q) begin
            shift_d = 8'h0D;
            cr_d    = 1'b1;
          end else begin
            shift_d = head;
            pop     = 1'b1;
            cr_d    = 1'b0;
          end
`else
          shift_d = head;
          pop     = 1'b1;
`endif
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d = wr_q + (FIFO_LOG2 + 1)'(push);
    rd_d = rd_q + (FIFO_LOG2 + 1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
`ifdef PUTC_CRLF_EN
      cr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
`ifdef PUTC_CRLF_EN
      cr_q    <= cr_d;
`endif
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[FIFO_LOG2-1:0]] <= putc_char;
  end

  assign putc_ready = !full;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_putc_uart_tx.sv
// Directed bench for putc_uart_tx at CLK_DIV=4, FIFO_LOG2=2: frame shape, latency,
// back-to-back spacing, FIFO full/overflow, mid-frame reset and LF handling.
module tb_putc_uart_tx;
  localparam int CLK_DIV   = 4;
  localparam int FIFO_LOG2 = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       putc = 1'b0;
  logic [7:0] putc_char = 8'h00;
  logic       putc_ready, tx, busy, overflow;
  logic [1:0] dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [255:0] tx_rec, busy_rec, exp_v;

  putc_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_LOG2(FIFO_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .putc(putc), .putc_char(putc_char),
    .putc_ready(putc_ready), .tx(tx), .busy(busy), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    putc  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Byte is sampled by the next posedge; returns just after that edge.
  task automatic put(input logic [7:0] c);
    putc      = 1'b1;
    putc_char = c;
    @(posedge clk);
    #1;
    putc = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sample j is taken on the negedge following the j-th posedge from now.
  task automatic record(input int n);
    tx_rec   = '1;
    busy_rec = '0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      tx_rec[j]   = tx;
      busy_rec[j] = busy;
    end
  endtask

  // Expected line levels for one frame placed at sample offset off (may be negative).
  function automatic logic [255:0] place(input logic [255:0] v, input logic [7:0] b,
                                         input int off);
    logic [9:0]   bits;
    logic [255:0] r;
    r    = v;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * CLK_DIV; i++) begin
      if (off + i >= 0 && off + i < 256) r[off + i] = bits[i / CLK_DIV];
    end
    return r;
  endfunction

  initial begin
    // Reset values
    do_reset();
    chk(tx, 1'b1, "rst_tx");
    chk(putc_ready, 1'b1, "rst_ready");
    chk(busy, 1'b0, "rst_busy");
    chk(overflow, 1'b0, "rst_overflow");

    // Single 'A': latency, frame bits, busy duration
    put(8'h41);
    record(45);
    chk(tx_rec[0], 1'b1, "A_tx_before_start");
    chk(tx_rec[1], 1'b0, "A_tx_falls_next_clk");
    exp_v = place('1, 8'h41, 1);
    chk(tx_rec, exp_v, "A_frame");
    chk($countones(busy_rec), 41, "A_busy_len");
    chk(busy_rec[0], 1'b1, "A_busy_first");
    chk(busy_rec[41], 1'b0, "A_busy_drop");

    // 'H','i' on consecutive cycles: one idle clock between frames
    put(8'h48);
    put(8'h69);
    record(90);
    exp_v = place('1, 8'h48, 0);
    exp_v = place(exp_v, 8'h69, 41);
    chk(tx_rec, exp_v, "Hi_frames");
    chk(tx_rec[40], 1'b1, "Hi_idle_gap");

    // Depth-4 FIFO: 6 puts while the first frame holds TX
    do_reset();
    put(8'h31);
    put(8'h32);
    put(8'h33);
    put(8'h34);
    put(8'h35);
    @(negedge clk);
    chk(putc_ready, 1'b0, "ovf_full_ready");
    chk(overflow, 1'b0, "ovf_not_yet");
    put(8'h36);
    @(negedge clk);
    chk(putc_ready, 1'b0, "ovf_ready_after_drop");
    chk(overflow, 1'b1, "ovf_set");
    record(210);
    exp_v = '1;
    for (int k = 0; k < 5; k++) exp_v = place(exp_v, 8'h31 + 8'(k), 41 * k - 5);
    chk(tx_rec, exp_v, "ovf_five_frames");
    chk(busy, 1'b0, "ovf_busy_end");
    chk(putc_ready, 1'b1, "ovf_ready_end");
    chk(overflow, 1'b1, "ovf_sticky");

    // Full FIFO with a put on the very edge IDLE pops: byte still dropped
    do_reset();
    put(8'h5A);
    put(8'hC3);
    put(8'h81);
    put(8'h7E);
    put(8'h02);
    @(negedge clk);
    chk(putc_ready, 1'b0, "pp_full");
    idle_cycles(37);
    @(negedge clk);
    chk(putc_ready, 1'b0, "pp_full_at_idle");
    chk(overflow, 1'b0, "pp_no_ovf_yet");
    put(8'hEE);
    @(negedge clk);
    chk(overflow, 1'b1, "pp_ovf");
    chk(putc_ready, 1'b1, "pp_count3_ready");
    chk(busy, 1'b1, "pp_busy");
    record(175);
    exp_v = place('1, 8'hC3, -1);
    exp_v = place(exp_v, 8'h81, 40);
    exp_v = place(exp_v, 8'h7E, 81);
    exp_v = place(exp_v, 8'h02, 122);
    chk(tx_rec, exp_v, "pp_frames_no_drop_byte");

    // Reset during DATA bit 3 of 0x35, with a second byte queued
    do_reset();
    put(8'h35);
    put(8'h5A);
    idle_cycles(17);
    @(negedge clk);
    chk(tx, 1'b0, "mid_bit3_level");
    rst_n = 1'b0;
    #1;
    chk(tx, 1'b1, "mid_rst_tx");
    chk(busy, 1'b0, "mid_rst_busy");
    chk(putc_ready, 1'b1, "mid_rst_ready");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    record(60);
    chk(tx_rec, '1, "mid_no_frames");
    chk(busy_rec, '0, "mid_no_busy");

    // Line feed
    do_reset();
    put(8'h0A);
    record(90);
`ifdef PUTC_CRLF_EN
    exp_v = place('1, 8'h0D, 1);
    exp_v = place(exp_v, 8'h0A, 42);
`else
    exp_v = place('1, 8'h0A, 1);
`endif
    chk(tx_rec, exp_v, "lf_frames");
    chk(busy, 1'b0, "lf_busy_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
